// File: rtl/CorePack.sv
// Core-wide shared types.
//   data_t : machine-width data word (RV64).
package CorePack;

    localparam int XLEN = 64;

    typedef logic [XLEN-1:0] data_t;

endpackage : CorePack

// File: rtl/CsrPack.sv
// CSR address map, mstatus bit positions and mcause encodings shared by
// the CSR file and anything that decodes CSR instructions.
package CsrPack;

    import CorePack::*;

    typedef logic [11:0] csr_addr_t;

    localparam csr_addr_t CSR_MSTATUS  = 12'h300;
    localparam csr_addr_t CSR_MIE      = 12'h304;
    localparam csr_addr_t CSR_MTVEC    = 12'h305;
    localparam csr_addr_t CSR_MSCRATCH = 12'h340;
    localparam csr_addr_t CSR_MEPC     = 12'h341;
    localparam csr_addr_t CSR_MCAUSE   = 12'h342;
    localparam csr_addr_t CSR_MTVAL    = 12'h343;
    localparam csr_addr_t CSR_MIP      = 12'h344;
    localparam csr_addr_t CSR_MCYCLE   = 12'hB00;
    localparam csr_addr_t CSR_MINSTRET = 12'hB02;
    localparam csr_addr_t CSR_MHARTID  = 12'hF14;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam data_t CAUSE_INSN_MISALIGNED = 64'd0;
    localparam data_t CAUSE_INSN_FAULT      = 64'd1;
    localparam data_t CAUSE_ILLEGAL_INSN    = 64'd2;
    localparam data_t CAUSE_BREAKPOINT      = 64'd3;
    localparam data_t CAUSE_ECALL_M         = 64'd11;

    function automatic logic csr_is_impl(input csr_addr_t addr);
        logic impl;
        impl = 1'b0;
        case (addr)
            CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC,
            CSR_MCAUSE, CSR_MTVAL, CSR_MIP, CSR_MCYCLE, CSR_MINSTRET,
            CSR_MHARTID: impl = 1'b1;
            default:     impl = 1'b0;
        endcase
        return impl;
    endfunction

endpackage : CsrPack

// File: rtl/csr_counter.sv
// 64-bit free-running counter with software load.
//   clk, rst   : clock, synchronous active-high reset (clears to 0)
//   inc        : advance by one this cycle (wraps at 2^64-1)
//   load       : take load_data instead; the increment is dropped
//   load_data  : value loaded when load is high
//   count      : current count
module csr_counter
    import CorePack::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  inc,
    input  logic  load,
    input  data_t load_data,
    output data_t count
);

    data_t count_q;
    data_t count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_data;
        end else if (inc) begin
            count_d = count_q + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : csr_counter

// File: rtl/csr_file.sv
// Machine-mode CSR file for a single-hart RV64 core.
//   clk, rst          : clock, synchronous active-high reset
//   csr_raddr/rdata   : combinational read port (current state, no bypass)
//   csr_illegal       : csr_raddr is not an implemented CSR
//   csr_we/waddr/wdata: write port, committed at the next rising edge
//   trap_*            : exception entry (mepc/mcause/mtval capture)
//   mret_valid        : return from trap
//   retire_valid      : one instruction retired (minstret increment)
//   redirect_valid/pc : fetch redirect for trap entry or mret
module csr_file
    import CorePack::*;
    import CsrPack::*;
#(
    parameter data_t HART_ID     = 64'h0,
    parameter data_t MTVEC_RESET = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] csr_raddr,
    output logic [63:0] csr_rdata,
    output logic        csr_illegal,
    input  logic        csr_we,
    input  logic [11:0] csr_waddr,
    input  logic [63:0] csr_wdata,
    input  logic        trap_valid,
    input  logic [63:0] trap_pc,
    input  logic [63:0] trap_cause,
    input  logic [63:0] trap_tval,
    input  logic        mret_valid,
    input  logic        retire_valid,
    output logic        redirect_valid,
    output logic [63:0] redirect_pc
);

    logic  mstatus_mie_q,  mstatus_mie_d;
    logic  mstatus_mpie_q, mstatus_mpie_d;
    data_t mie_q,      mie_d;
    data_t mtvec_q,    mtvec_d;
    data_t mscratch_q, mscratch_d;
    data_t mepc_q,     mepc_d;
    data_t mcause_q,   mcause_d;
    data_t mtval_q,    mtval_d;
    data_t mip_q,      mip_d;

    data_t mcycle, minstret;
    data_t mstatus_rd;
    logic  sw_we;

    // Trap and mret both outrank a software write in the same cycle.
    assign sw_we = csr_we && !trap_valid && !mret_valid;

    csr_counter u_mcycle (
        .clk       (clk),
        .rst       (rst),
        .inc       (1'b1),
        .load      (sw_we && (csr_waddr == CSR_MCYCLE)),
        .load_data (csr_wdata),
        .count     (mcycle)
    );

    csr_counter u_minstret (
        .clk       (clk),
        .rst       (rst),
        .inc       (retire_valid),
        .load      (sw_we && (csr_waddr == CSR_MINSTRET)),
        .load_data (csr_wdata),
        .count     (minstret)
    );

    // Only MIE/MPIE are stored; MPP is hardwired to machine mode.
    always_comb begin
        mstatus_rd = '0;
        mstatus_rd[MSTATUS_MIE]  = mstatus_mie_q;
        mstatus_rd[MSTATUS_MPIE] = mstatus_mpie_q;
        mstatus_rd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    end

    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;
        mip_d          = mip_q;

        if (trap_valid) begin
            mepc_d         = {trap_pc[63:1], 1'b0};
            mcause_d       = trap_cause;
            mtval_d        = trap_tval;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (mret_valid) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end else if (sw_we) begin
            case (csr_waddr)
                CSR_MSTATUS: begin
                    mstatus_mie_d  = csr_wdata[MSTATUS_MIE];
                    mstatus_mpie_d = csr_wdata[MSTATUS_MPIE];
                end
                CSR_MIE:      mie_d      = csr_wdata;
                CSR_MTVEC:    mtvec_d    = {csr_wdata[63:2], 2'b00};
                CSR_MSCRATCH: mscratch_d = csr_wdata;
                CSR_MEPC:     mepc_d     = {csr_wdata[63:1], 1'b0};
                CSR_MCAUSE:   mcause_d   = csr_wdata;
                CSR_MTVAL:    mtval_d    = csr_wdata;
                CSR_MIP:      mip_d      = csr_wdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mtvec_q        <= MTVEC_RESET;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
            mip_q          <= '0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
            mip_q          <= mip_d;
        end
    end

    always_comb begin
        csr_rdata = '0;
        case (csr_raddr)
            CSR_MSTATUS:  csr_rdata = mstatus_rd;
            CSR_MIE:      csr_rdata = mie_q;
            CSR_MTVEC:    csr_rdata = mtvec_q;
            CSR_MSCRATCH: csr_rdata = mscratch_q;
            CSR_MEPC:     csr_rdata = mepc_q;
            CSR_MCAUSE:   csr_rdata = mcause_q;
            CSR_MTVAL:    csr_rdata = mtval_q;
            CSR_MIP:      csr_rdata = mip_q;
            CSR_MCYCLE:   csr_rdata = mcycle;
            CSR_MINSTRET: csr_rdata = minstret;
            CSR_MHARTID:  csr_rdata = HART_ID;
            default:      csr_rdata = '0;
        endcase
    end

    assign csr_illegal = !csr_is_impl(csr_raddr);

    // Redirect targets use the pre-edge register values.
    assign redirect_valid = !rst && (trap_valid || mret_valid);
    assign redirect_pc    = trap_valid ? mtvec_q : mepc_q;

endmodule : csr_file

// File: tb/tb_csr_file.sv
module tb_csr_file;

    localparam logic [63:0] HART_ID     = 64'h0000_0000_0000_0007;
    localparam logic [63:0] MTVEC_RESET = 64'h0000_0000_8000_0000;

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MINSTRET = 12'hB02;
    localparam logic [11:0] A_MHARTID  = 12'hF14;
    localparam logic [11:0] A_BOGUS    = 12'h7C0;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] csr_raddr;
    logic [63:0] csr_rdata;
    logic        csr_illegal;
    logic        csr_we;
    logic [11:0] csr_waddr;
    logic [63:0] csr_wdata;
    logic        trap_valid;
    logic [63:0] trap_pc, trap_cause, trap_tval;
    logic        mret_valid;
    logic        retire_valid;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] exp_q[$];
    logic [63:0] got, exp;

    csr_file #(.HART_ID(HART_ID), .MTVEC_RESET(MTVEC_RESET)) dut (
        .clk            (clk),
        .rst            (rst),
        .csr_raddr      (csr_raddr),
        .csr_rdata      (csr_rdata),
        .csr_illegal    (csr_illegal),
        .csr_we         (csr_we),
        .csr_waddr      (csr_waddr),
        .csr_wdata      (csr_wdata),
        .trap_valid     (trap_valid),
        .trap_pc        (trap_pc),
        .trap_cause     (trap_cause),
        .trap_tval      (trap_tval),
        .mret_valid     (mret_valid),
        .retire_valid   (retire_valid),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic drive_idle();
        csr_we       = 1'b0;
        csr_waddr    = '0;
        csr_wdata    = '0;
        trap_valid   = 1'b0;
        trap_pc      = '0;
        trap_cause   = '0;
        trap_tval    = '0;
        mret_valid   = 1'b0;
        retire_valid = 1'b0;
    endtask

    // Called right after a falling edge; each read takes 1 ns.
    task automatic rd(input logic [11:0] a, output logic [63:0] d);
        csr_raddr = a;
        #1;
        d = csr_rdata;
    endtask

    // Drive a write for one cycle; returns at the following falling edge.
    task automatic wr(input logic [11:0] a, input logic [63:0] d);
        @(negedge clk);
        csr_we    = 1'b1;
        csr_waddr = a;
        csr_wdata = d;
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        drive_idle();
        @(negedge clk);
        // Reset must win over trap and write in the same cycle.
        trap_valid = 1'b1; trap_pc = 64'h1234; trap_cause = 64'd5;
        csr_we = 1'b1; csr_waddr = A_MSCRATCH; csr_wdata = 64'h55;
        #1;
        exp_q.push_back(64'd0);
        got = {63'd0, redirect_valid}; exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL reset_redirect got %h exp %h", got, exp); end
        @(negedge clk);
        drive_idle();
        exp_q.push_back(64'h1800);
        exp_q.push_back(MTVEC_RESET);
        exp_q.push_back(64'd0);
        exp_q.push_back(64'd0);
        rd(A_MSTATUS, got); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL reset_mstatus got %h exp %h", got, exp); end
        rd(A_MTVEC, got); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL reset_mtvec got %h exp %h", got, exp); end
        rd(A_MEPC, got); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL reset_mepc got %h exp %h", got, exp); end
        rd(A_MSCRATCH, got); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL reset_mscratch got %h exp %h", got, exp); end
        rst = 1'b0;
        exp_q.push_back(64'd0);
        rd(A_MCYCLE, got); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL reset_mcycle got %h exp %h", got, exp); end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        csr_we = 1'b1; csr_waddr = A_MSCRATCH; csr_wdata = 64'hDEAD_BEEF;
        exp_q.push_back(64'd0);
        rd(A_MSCRATCH, got); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL wr_same_cycle got %h exp %h", got, exp); end
        exp_q.push_back(64'hDEAD_BEEF);
        @(negedge clk);
        drive_idle();
        rd(A_MSCRATCH, got); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL wr_next_cycle got %h exp %h", got, exp); end
    endtask

    task automatic test_warl();
        wr(A_MSTATUS, 64'hFFFF_FFFF_FFFF_FFFF);
        exp_q.push_back(64'h1888);
        rd(A_MSTATUS, got); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL warl_mstatus got %h exp %h", got, exp); end
        wr(A_MTVEC, 64'h8000_0007);
        exp_q.push_back(64'h8000_0004);
        rd(A_MTVEC, got); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL warl_mtvec got %h exp %h", got, exp); end
        wr(A_MEPC, 64'h0000_0000_0000_1003);
        exp_q.push_back(64'h0000_0000_0000_1002);
        rd(A_MEPC, got); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL warl_mepc got %h exp %h", got, exp); end
    endtask

    task automatic test_illegal();
        wr(A_MHARTID, 64'hAAAA);
        wr(A_BOGUS, 64'hBBBB);
        exp_q.push_back(HART_ID);
        exp_q.push_back(64'd0);
        exp_q.push_back(64'd1);
        exp_q.push_back(64'd0);
        rd(A_MHARTID, got); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL mhartid got %h exp %h", got, exp); end
        rd(A_BOGUS, got); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL bogus_rdata got %h exp %h", got, exp); end
        got = {63'd0, csr_illegal}; exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL bogus_illegal got %h exp %h", got, exp); end
        rd(A_MTVAL, got);
        got = {63'd0, csr_illegal}; exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL mtval_illegal got %h exp %h", got, exp); end
    endtask

    task automatic test_trap();
        wr(A_MTVEC, 64'h100);
        wr(A_MSTATUS, 64'h8);
        trap_valid = 1'b1; trap_pc = 64'h2000; trap_cause = 64'd2; trap_tval = 64'hBAD;
        exp_q.push_back(64'd1);
        exp_q.push_back(64'h100);
        #1;
        got = {63'd0, redirect_valid}; exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL trap_redirect_valid got %h exp %h", got, exp); end
        got = redirect_pc; exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL trap_redirect_pc got %h exp %h", got, exp); end
        exp_q.push_back(64'h2000);
        exp_q.push_back(64'd2);
        exp_q.push_back(64'hBAD);
        exp_q.push_back(64'h1880);
        @(negedge clk);
        drive_idle();
        rd(A_MEPC, got); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL trap_mepc got %h exp %h", got, exp); end
        rd(A_MCAUSE, got); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL trap_mcause got %h exp %h", got, exp); end
        rd(A_MTVAL, got); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL trap_mtval got %h exp %h", got, exp); end
        rd(A_MSTATUS, got); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL trap_mstatus got %h exp %h", got, exp); end
        exp_q.push_back(64'd0);
        got = {63'd0, redirect_valid}; exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL idle_redirect got %h exp %h", got, exp); end
    endtask

    task automatic test_mret();
        // mret also carries a write to mscratch, which must be dropped.
        @(negedge clk);
        mret_valid = 1'b1;
        csr_we = 1'b1; csr_waddr = A_MSCRATCH; csr_wdata = 64'h1111;
        exp_q.push_back(64'd1);
        exp_q.push_back(64'h2000);
        #1;
        got = {63'd0, redirect_valid}; exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL mret_redirect_valid got %h exp %h", got, exp); end
        got = redirect_pc; exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL mret_redirect_pc got %h exp %h", got, exp); end
        exp_q.push_back(64'h1888);
        exp_q.push_back(64'hDEAD_BEEF);
        @(negedge clk);
        drive_idle();
        rd(A_MSTATUS, got); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL mret_mstatus got %h exp %h", got, exp); end
        rd(A_MSCRATCH, got); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL mret_drops_write got %h exp %h", got, exp); end
    endtask

    task automatic test_simultaneous();
        @(negedge clk);
        trap_valid = 1'b1; trap_pc = 64'h3001; trap_cause = 64'd7; trap_tval = 64'h77;
        mret_valid = 1'b1;
        csr_we = 1'b1; csr_waddr = A_MEPC; csr_wdata = 64'h4444;
        exp_q.push_back(64'h100);
        #1;
        got = redirect_pc; exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL simul_redirect_pc got %h exp %h", got, exp); end
        exp_q.push_back(64'h3000);
        exp_q.push_back(64'd7);
        exp_q.push_back(64'h1880);
        @(negedge clk);
        drive_idle();
        rd(A_MEPC, got); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL simul_mepc got %h exp %h", got, exp); end
        rd(A_MCAUSE, got); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL simul_mcause got %h exp %h", got, exp); end
        rd(A_MSTATUS, got); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL simul_mstatus got %h exp %h", got, exp); end
    endtask

    task automatic test_counter_wrap();
        wr(A_MCYCLE, 64'hFFFF_FFFF_FFFF_FFFF);
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
        exp_q.push_back(64'd0);
        exp_q.push_back(64'd1);
        rd(A_MCYCLE, got); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL mcycle_load got %h exp %h", got, exp); end
        @(negedge clk);
        rd(A_MCYCLE, got); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL mcycle_wrap got %h exp %h", got, exp); end
        @(negedge clk);
        rd(A_MCYCLE, got); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL mcycle_inc got %h exp %h", got, exp); end

        @(negedge clk);
        csr_we = 1'b1; csr_waddr = A_MINSTRET; csr_wdata = 64'd5; retire_valid = 1'b1;
        exp_q.push_back(64'd5);
        exp_q.push_back(64'd8);
        @(negedge clk);
        drive_idle();
        rd(A_MINSTRET, got); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL minstret_load got %h exp %h", got, exp); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            retire_valid = (i != 1);
        end
        @(negedge clk);
        drive_idle();
        rd(A_MINSTRET, got); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL minstret_retire got %h exp %h", got, exp); end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        trap_valid = 1'b1; trap_pc = 64'h500; trap_cause = 64'd11;
        exp_q.push_back(64'h500);
        @(negedge clk);
        drive_idle();
        rd(A_MEPC, got); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL pre_reset_mepc got %h exp %h", got, exp); end
        @(negedge clk);
        rst = 1'b1;
        exp_q.push_back(64'd0);
        exp_q.push_back(MTVEC_RESET);
        exp_q.push_back(64'd0);
        exp_q.push_back(64'd1);
        @(negedge clk);
        rst = 1'b0;
        rd(A_MEPC, got); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL rst_mepc got %h exp %h", got, exp); end
        rd(A_MTVEC, got); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL rst_mtvec got %h exp %h", got, exp); end
        rd(A_MCYCLE, got); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL rst_mcycle0 got %h exp %h", got, exp); end
        @(negedge clk);
        rd(A_MCYCLE, got); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL rst_mcycle1 got %h exp %h", got, exp); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        csr_raddr = '0;
        drive_idle();
        test_reset();
        test_write_read();
        test_warl();
        test_illegal();
        test_trap();
        test_mret();
        test_simultaneous();
        test_counter_wrap();
        test_mid_reset();
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_csr_file

// File: doc/csr_file.md
CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 SHALL have parameter HART_ID, default 64'h0, value returned by mhartid.
REQ-002 SHALL have parameter MTVEC_RESET, default 64'h0, reset value of mtvec.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port csr_raddr  input  12  CSR read address.
REQ-006 SHALL have port csr_rdata  output  64  CSR read data (combinational), feeds CSR ALU operand csr_a.
REQ-007 SHALL have port csr_illegal  output  1  csr_raddr is unimplemented.
REQ-008 SHALL have port csr_we  input  1  write enable.
REQ-009 SHALL have port csr_waddr  input  12  write address.
REQ-010 SHALL have port csr_wdata  input  64  write data (CSR ALU result).
REQ-011 SHALL have port trap_valid  input  1  take exception this cycle.
REQ-012 SHALL have port trap_pc  input  64  faulting PC.
REQ-013 SHALL have port trap_cause  input  64  mcause value.
REQ-014 SHALL have port trap_tval  input  64  mtval value.
REQ-015 SHALL have port mret_valid  input  1  mret retires this cycle.
REQ-016 SHALL have port retire_valid  input  1  one instruction retires.
REQ-017 SHALL have port redirect_valid  output  1  flush and redirect fetch.
REQ-018 SHALL have port redirect_pc  output  64  redirect target.

Function
REQ-019 SHALL implement mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344, mcycle 0xB00, minstret 0xB02, mhartid 0xF14; others assert csr_illegal and read 0.
REQ-020 SHALL return current register state on csr_rdata; no forwarding of same-cycle writes.
REQ-021 SHALL commit writes at the next rising edge; read-back is visible the following cycle.
REQ-022 SHALL ignore writes to mhartid and to unimplemented addresses.
REQ-023 SHALL treat mstatus as WARL: only MIE[3], MPIE[7] are writable; MPP[12:11] always reads 2'b11; other bits read 0.
REQ-024 SHALL force mtvec[1:0] and mepc[0] to 0 on any write (direct mode only).
REQ-025 SHALL increment mcycle by 1 each cycle out of reset, wrapping 2^64-1 -> 0.
REQ-026 SHALL increment minstret by 1 when retire_valid is high, with the same wrap-around.
REQ-027 SHALL, when a software write targets mcycle or minstret, load csr_wdata and suppress that cycle's increment.
REQ-028 SHALL, on trap_valid, set mepc=trap_pc (bit0 cleared), mcause=trap_cause, mtval=trap_tval, MPIE=MIE, MIE=0.
REQ-029 SHALL, on trap_valid, assert redirect_valid combinationally with redirect_pc equal to the pre-edge mtvec.
REQ-030 SHALL, on mret_valid, set MIE=MPIE and MPIE=1, and assert redirect_valid with redirect_pc equal to the pre-edge mepc.
REQ-031 SHALL apply priority trap_valid > mret_valid > csr_we; the losing register updates are dropped that cycle.
REQ-032 SHALL still let counters advance in a trap or mret cycle.
REQ-033 SHALL hold redirect_valid low whenever neither trap_valid nor mret_valid is high.

Reset
REQ-034 SHALL, while rst is high at an edge, clear all CSRs to 0 except mtvec=MTVEC_RESET and MPP=2'b11.
REQ-035 SHALL give rst precedence over trap, mret, write and increment in the same cycle.
REQ-036 SHALL drive redirect_valid=0 while rst is high.

Structure
REQ-037 SHALL take CSR address constants, mstatus bit positions and mcause encodings from the shared CsrPack package; data_t comes from CorePack.
REQ-038 SHALL instantiate one 64-bit counter sub-module, csr_counter, twice (mcycle, minstret), with inc, load and load-data inputs.

Verification
REQ-039 SHALL cover write-then-read: write mscratch=64'hDEAD_BEEF -> read is old value in the same cycle and 64'hDEAD_BEEF in the next cycle.
REQ-040 SHALL cover WARL: write mstatus=64'hFFFF_FFFF_FFFF_FFFF -> read 64'h1888; write mtvec=64'h8000_0007 -> read 64'h8000_0004.
REQ-041 SHALL cover trap: mtvec=0x100, MIE=1, trap_pc=0x2000, cause=2 -> redirect 0x100; next cycle mepc=0x2000, mcause=2, MIE=0, MPIE=1.
REQ-042 SHALL cover a simultaneous event: trap_valid and mret_valid and csr_we to mepc all in one cycle -> trap values win; mepc=trap_pc.
REQ-043 SHALL cover counter wrap: load mcycle=2^64-1 -> reads 0 two cycles later; a write cycle holds the written value without increment.
REQ-044 SHALL cover mid-run reset: pulse rst after a trap -> mepc=0, mtvec=MTVEC_RESET, and mcycle restarts from 0.
